// File: rtl/prm_pkg.sv
// Shared definitions for the scan controller and its coordinate counter.
// Holds the FSM state encoding, frame and word widths, and the per-axis
// widths of the packed {x,y,z} coordinate.
package prm_pkg;

   localparam int FRAME_LEN = 32;
   localparam int WORD_W    = 32;
   localparam int XYZ_W     = 14;
   localparam int X_W       = 4;
   localparam int Y_W       = 5;
   localparam int Z_W       = 5;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_SYNC  = 3'd1;
   localparam state_t ST_ACCUM = 3'd2;
   localparam state_t ST_FLUSH = 3'd3;
   localparam state_t ST_READ  = 3'd4;

endpackage

// File: rtl/prm_xyz_cnt.sv
// Wrapping three-axis coordinate counter, z fastest, then y, then x.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   load           latch x/y/z limits and clear the coordinate
//   enable         advance one coordinate (ignored once on the last one)
//   x_lim..z_lim   inclusive limits captured on load
//   xyz            packed {x,y,z} coordinate
//   last           coordinate equals the latched limits
module prm_xyz_cnt
   import prm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             enable,
   input  logic [X_W-1:0]   x_lim,
   input  logic [Y_W-1:0]   y_lim,
   input  logic [Z_W-1:0]   z_lim,
   output logic [XYZ_W-1:0] xyz,
   output logic             last
);

   logic [X_W-1:0] x, x_top;
   logic [Y_W-1:0] y, y_top;
   logic [Z_W-1:0] z, z_top;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x     <= '0;
         y     <= '0;
         z     <= '0;
         x_top <= '0;
         y_top <= '0;
         z_top <= '0;
      end else if (load) begin
         x_top <= x_lim;
         y_top <= y_lim;
         z_top <= z_lim;
         x     <= '0;
         y     <= '0;
         z     <= '0;
      end else if (enable && !last) begin
         if (z == z_top) begin
            z <= '0;
            if (y == y_top) begin
               y <= '0;
               x <= x + X_W'(1);
            end else begin
               y <= y + Y_W'(1);
            end
         end else begin
            z <= z + Z_W'(1);
         end
      end
   end

   assign last = (x == x_top) && (y == y_top) && (z == z_top);
   assign xyz  = {x, y, z};

endmodule

// File: rtl/prm_scan_ctrl.sv
// Scan controller: steps the checker through an {x,y,z} grid, one 32-beat
// frame per coordinate aligned to the checker frame counter, then reads the
// result banks back word by word over a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start
// SYNC  | waiting for data_sel_in == 31 so the next frame starts at beat 0
// ACCUM | 32 beats per coordinate, coordinate held constant within a frame
// FLUSH | waiting for data_sel_in == 1 so the final frame is accumulated
// READ  | streaming N_BANK*N_WORD result words
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               begin a scan (IDLE only); x/y/z_max sampled then
//   xyz_out             coordinate to the checker
//   data_sel_in         checker frame counter
//   sel1, sel2          checker bank / word select (0 outside READ)
//   result_in           checker result word
//   rd_data, rd_valid,
//   rd_ready            readout stream
//   busy, done          not-IDLE flag, end-of-readout pulse
module prm_scan_ctrl
   import prm_pkg::*;
#(
   parameter int N_BANK = 2,
   parameter int N_WORD = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [X_W-1:0]    x_max,
   input  logic [Y_W-1:0]    y_max,
   input  logic [Z_W-1:0]    z_max,
   output logic [XYZ_W-1:0]  xyz_out,
   input  logic [4:0]        data_sel_in,
   output logic [2:0]        sel1,
   output logic [7:0]        sel2,
   input  logic [WORD_W-1:0] result_in,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              busy,
   output logic              done
);

   localparam logic [4:0] BEAT_LAST = 5'(FRAME_LEN - 1);
   localparam logic [2:0] SEL1_LAST = 3'(N_BANK - 1);
   localparam logic [7:0] SEL2_LAST = 8'(N_WORD - 1);

   state_t     state;
   logic [4:0] beat;
   logic       load, advance, last;
   logic       in_step, hs, hs_last;

   assign load    = (state == ST_IDLE) && start;
   assign in_step = (beat == data_sel_in);
   assign advance = (state == ST_ACCUM) && in_step && (beat == BEAT_LAST);
   assign hs      = rd_valid && rd_ready;
   assign hs_last = hs && (sel1 == SEL1_LAST) && (sel2 == SEL2_LAST);

   prm_xyz_cnt u_xyz (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .enable (advance),
      .x_lim  (x_max),
      .y_lim  (y_max),
      .z_lim  (z_max),
      .xyz    (xyz_out),
      .last   (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         beat  <= '0;
         sel1  <= '0;
         sel2  <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) state <= ST_SYNC;
            end
            ST_SYNC: begin
               if (data_sel_in == BEAT_LAST) begin
                  state <= ST_ACCUM;
                  beat  <= '0;
               end
            end
            ST_ACCUM: begin
               // Lost lock with the checker frame: the partial frame is
               // discarded and the same coordinate is re-run from beat 0.
               if (!in_step) begin
                  state <= ST_SYNC;
                  beat  <= '0;
               end else begin
                  beat <= beat + 5'd1;
                  if (beat == BEAT_LAST && last) state <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (data_sel_in == 5'd1) state <= ST_READ;
            end
            ST_READ: begin
               if (hs_last) begin
                  state <= ST_IDLE;
                  sel1  <= '0;
                  sel2  <= '0;
                  done  <= 1'b1;
               end else if (hs) begin
                  if (sel2 == SEL2_LAST) begin
                     sel2 <= '0;
                     sel1 <= sel1 + 3'd1;
                  end else begin
                     sel2 <= sel2 + 8'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign rd_valid = (state == ST_READ);
   assign rd_data  = rd_valid ? result_in : '0;
   assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_prm_scan_ctrl.sv
module tb_prm_scan_ctrl;

   localparam int N_BANK = 2;
   localparam int N_WORD = 16;
   localparam int N_TOT  = N_BANK * N_WORD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  x_max = '0;
   logic [4:0]  y_max = '0;
   logic [4:0]  z_max = '0;
   logic [13:0] xyz_out;
   logic [4:0]  ds_cnt = 5'd0;
   logic        ds_skip = 1'b0;
   logic [2:0]  sel1;
   logic [7:0]  sel2;
   logic [31:0] result_in;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  s1;
      logic [7:0]  s2;
      logic [31:0] w;
   } sb_t;

   typedef struct {
      int xm; int ym; int zm; int sd; int pat; int poke;
   } vec_t;

   sb_t         sb[$];
   logic [13:0] pts[$];
   vec_t        vecs[5];

   function automatic logic [31:0] model_word(logic [2:0] b, logic [7:0] w);
      return {16'hC0DE, 5'd0, b, w};
   endfunction

   always #5 clk = ~clk;

   // free-running checker frame counter; ds_skip forces a discontinuity
   always @(posedge clk) ds_cnt <= ds_cnt + 5'd1 + {4'd0, ds_skip};

   assign result_in = model_word(sel1, sel2);

   prm_scan_ctrl #(.N_BANK(N_BANK), .N_WORD(N_WORD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .x_max       (x_max),
      .y_max       (y_max),
      .z_max       (z_max),
      .xyz_out     (xyz_out),
      .data_sel_in (ds_cnt),
      .sel1        (sel1),
      .sel2        (sel2),
      .result_in   (result_in),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .busy        (busy),
      .done        (done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_to(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting at %0t", name, $time);
   endtask

   task automatic fill_sb(input int xm, input int ym, input int zm);
      sb_t e;
      pts.delete();
      sb.delete();
      for (int x = 0; x <= xm; x++)
         for (int y = 0; y <= ym; y++)
            for (int z = 0; z <= zm; z++)
               pts.push_back({4'(x), 5'(y), 5'(z)});
      for (int i = 0; i < N_TOT; i++) begin
         e.s1 = 3'(i / N_WORD);
         e.s2 = 8'(i % N_WORD);
         e.w  = model_word(e.s1, e.s2);
         sb.push_back(e);
      end
   endtask

   // sd < 0: start right now; otherwise wait for that frame counter value
   task automatic do_start(input int xm, input int ym, input int zm, input int sd,
                           output int s_cyc);
      int g = 0;
      int sd_used;
      if (sd >= 0) begin
         while (int'(ds_cnt) != sd && g < 64) begin
            tick();
            g++;
         end
         if (g >= 64) fail_to("start_align");
      end
      sd_used = int'(ds_cnt);
      x_max = 4'(xm);
      y_max = 5'(ym);
      z_max = 5'(zm);
      start = 1'b1;
      tick();
      start = 1'b0;
      // limits must have been captured on the start edge only
      x_max = 4'hF;
      y_max = 5'h1F;
      z_max = 5'h1F;
      s_cyc = ((30 - sd_used) & 31) + 1;
   endtask

   task automatic chk_hold(input logic [13:0] xyz, input int n);
      for (int i = 0; i < n; i++) begin
         chk("scan", 64'({busy, rd_valid, done, xyz_out}), 64'({1'b1, 1'b0, 1'b0, xyz}));
         tick();
      end
   endtask

   task automatic read_phase(input int pat, input int poke);
      logic [3:0] patv = 4'b1001;
      int  k = 0;
      int  guard = 0;
      logic rdy;
      sb_t e;
      while (sb.size() > 0 && guard < 400) begin
         e = sb[0];
         chk("read", 64'({rd_valid, done, busy, sel1, sel2, rd_data}),
             64'({1'b1, 1'b0, 1'b1, e.s1, e.s2, e.w}));
         rdy = (pat == 0) ? 1'b1 : patv[k % 4];
         rd_ready = rdy;
         if (poke == 2 && k == 5) begin
            start = 1'b1;
            x_max = 4'd3;
            y_max = 5'd3;
            z_max = 5'd3;
         end
         k++;
         tick();
         start = 1'b0;
         if (rdy) void'(sb.pop_front());
         guard++;
      end
      if (guard >= 400) fail_to("read_phase");
      rd_ready = 1'b0;
      chk("done_pulse", 64'({done, busy, rd_valid, sel1, sel2}),
          64'({1'b1, 1'b0, 1'b0, 3'd0, 8'd0}));
      tick();
      chk("done_clear", 64'({done, busy, rd_valid}), 64'({1'b0, 1'b0, 1'b0}));
   endtask

   task automatic run_vec(input vec_t v);
      int s;
      fill_sb(v.xm, v.ym, v.zm);
      do_start(v.xm, v.ym, v.zm, v.sd, s);
      chk_hold(14'd0, s);
      for (int p = 0; p < pts.size(); p++) begin
         if (v.poke == 1 && p == 0) begin
            chk_hold(pts[p], 20);
            start = 1'b1;
            x_max = '0;
            y_max = '0;
            z_max = '0;
            chk_hold(pts[p], 1);
            start = 1'b0;
            chk_hold(pts[p], 11);
         end else begin
            chk_hold(pts[p], 32);
         end
      end
      chk_hold(pts[pts.size()-1], 2);
      read_phase(v.pat, v.poke);
   endtask

   initial begin
      int s;
      vecs[0] = '{xm: 0, ym: 0, zm: 0, sd: 5,  pat: 0, poke: 0};
      vecs[1] = '{xm: 1, ym: 1, zm: 2, sd: 12, pat: 0, poke: 1};
      vecs[2] = '{xm: 0, ym: 0, zm: 0, sd: 20, pat: 1, poke: 2};
      vecs[3] = '{xm: 2, ym: 0, zm: 3, sd: 30, pat: 1, poke: 0};
      vecs[4] = '{xm: 0, ym: 3, zm: 0, sd: 0,  pat: 0, poke: 0};

      // reset state
      tick();
      tick();
      chk("reset", 64'({xyz_out, sel1, sel2, rd_valid, busy, done, rd_data}), 64'(0));
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // frame counter discontinuity during the second coordinate
      fill_sb(0, 0, 1);
      do_start(0, 0, 1, 8, s);
      chk_hold(14'd0, s);
      chk_hold(pts[0], 32);
      chk_hold(pts[1], 10);
      ds_skip = 1'b1;
      tick();
      ds_skip = 1'b0;
      chk_hold(pts[1], 54);
      read_phase(0, 0);

      // asynchronous reset in the middle of the fourth coordinate
      fill_sb(1, 1, 2);
      do_start(1, 1, 2, 3, s);
      chk_hold(14'd0, s);
      for (int p = 0; p < 3; p++) chk_hold(pts[p], 32);
      chk_hold(pts[3], 10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async", 64'({xyz_out, sel1, sel2, rd_valid, busy, done, rd_data}), 64'(0));
      tick();
      tick();
      chk("rst_hold", 64'({xyz_out, sel1, sel2, rd_valid, busy, done, rd_data}), 64'(0));

      // first edge after release must accept start; rescan from 000
      rst_n = 1'b1;
      fill_sb(1, 0, 0);
      do_start(1, 0, 0, -1, s);
      chk_hold(14'd0, s);
      for (int p = 0; p < pts.size(); p++) chk_hold(pts[p], 32);
      chk_hold(pts[pts.size()-1], 2);
      read_phase(1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
